// File: rtl/load_store_unit.sv
// MEM-stage load/store front end: word-aligned accesses to a byte-addressable data memory,
// read-modify-write for SB/SH, sign/zero extension for loads, and fault classification.
module load_store_unit #(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Mem_Addr,
  output logic [31:0] wr_data,
  input  logic [31:0] rd_data,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] RMW_RD = 2'd2;
  localparam logic [1:0] WRITE  = 2'd3;

  // Handshake: a request is taken on a rising edge where req_valid & req_ready;
  // req_ready is high only in IDLE, and resp_valid pulses for exactly one cycle.
  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] merged_q;
  logic [2:0]  funct3_q;

  logic [32:0] end_addr;
  logic        out_of_range;
  logic        bad_op;
  logic        bad_load;
  logic        bad_store;
  logic        is_illegal;
  logic        is_misaligned;

  always_comb begin
    end_addr      = {1'b0, addr[31:2], 2'b00} + 33'd3;
    out_of_range  = end_addr >= 33'(MEM_BYTES);
    bad_op        = req_read == req_write;
    bad_load      = req_read && (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    bad_store     = req_write && (funct3[2] || funct3[1:0] == 2'b11);
    is_illegal    = bad_op || bad_load || bad_store || out_of_range;
    is_misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                    (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  end

  // Lane selection: shifting by the byte offset brings the addressed byte/half to bit 0.
  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] load_ext;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  always_comb begin
    shamt    = {addr_q[1:0], 3'b000};
    shifted  = rd_data >> shamt;
    load_ext = rd_data;
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = rd_data;
    endcase
    lane_mask = (funct3_q[1:0] == 2'b00) ? (32'h0000_00FF << shamt) : (32'h0000_FFFF << shamt);
    merged    = (rd_data & ~lane_mask) | ((data_q << shamt) & lane_mask);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      merged_q   <= '0;
      funct3_q   <= '0;
      load_data  <= '0;
      resp_valid <= 1'b0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= addr;
            funct3_q <= funct3;
            data_q   <= store_data;
            if (is_illegal) begin
              resp_valid <= 1'b1;
              illegal    <= 1'b1;
            end else if (is_misaligned) begin
              resp_valid <= 1'b1;
              misaligned <= 1'b1;
            end else if (req_read) begin
              state <= LOAD;
            end else if (funct3[1:0] == 2'b10) begin
              state <= WRITE;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          load_data  <= load_ext;
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        RMW_RD: begin
          merged_q <= merged;
          state    <= WRITE;
        end
        WRITE: begin
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes come straight from the state so reset removes them immediately.
  always_comb begin
    req_ready = state == IDLE;
    MemRead   = state == LOAD || state == RMW_RD;
    MemWrite  = state == WRITE;
    Mem_Addr  = {addr_q[31:2], 2'b00};
    wr_data   = '0;
    if (state == WRITE) begin
      wr_data = (funct3_q[1:0] == 2'b10) ? data_q : merged_q;
    end
    state_dbg = state;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural byte-array memory, directed vector table,
// mid-operation reset sequence and randomized requests against a byte-level reference model.
module tb_load_store_unit;

  localparam int MEM_BYTES = 256;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_read;
  logic        req_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        misaligned;
  logic        illegal;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Mem_Addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [1:0]  state_dbg;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_write(req_write), .funct3(funct3), .addr(addr),
    .store_data(store_data), .resp_valid(resp_valid), .load_data(load_data),
    .misaligned(misaligned), .illegal(illegal), .MemRead(MemRead), .MemWrite(MemWrite),
    .Mem_Addr(Mem_Addr), .wr_data(wr_data), .rd_data(rd_data), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- data memory (environment) ----------------
  bit [7:0]    mem [MEM_BYTES];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;
  logic [7:0]  ma;

  assign ma      = Mem_Addr[7:0] & 8'hFC;
  assign rd_data = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};

  always @(posedge clk) begin
    if (MemWrite) begin
      {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]} <= wr_data;
    end
    if (bd_we) begin
      {mem[bd_addr + 8'd3], mem[bd_addr + 8'd2], mem[bd_addr + 8'd1], mem[bd_addr]} <= bd_data;
    end
  end

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
  endfunction

  // ---------------- scoreboard / reference model ----------------
  int          n_pass = 0;
  int          n_total = 0;
  bit [7:0]    ref_mem [MEM_BYTES];
  logic [31:0] last_load = '0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Byte-granular model of one request: returns expected flags, latency and strobe counts.
  task automatic model(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic e_ill, output logic e_mis,
                       output int e_lat, output int e_mr, output int e_mw);
    int n;
    logic [31:0] v;
    longint wa;
    wa    = longint'({a[31:2], 2'b00});
    e_ill = (rd == wr) || (rd && (f3 == 3 || f3 == 6 || f3 == 7)) || (wr && f3 > 2) ||
            (wa + 3 >= MEM_BYTES);
    n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e_mis = !e_ill && ((int'(a[1:0]) % n) != 0);
    e_lat = 1; e_mr = 0; e_mw = 0;
    if (!e_ill && !e_mis) begin
      if (rd) begin
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a[7:0]) + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        last_load = v;
        e_lat = 2; e_mr = 1;
      end else begin
        for (int i = 0; i < n; i++) ref_mem[int'(a[7:0]) + i] = d[8 * i +: 8];
        e_lat = (n == 4) ? 2 : 3;
        e_mr  = (n == 4) ? 0 : 1;
        e_mw  = 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_word(input logic [7:0] a, input logic [31:0] v);
    bd_we = 1'b1; bd_addr = a; bd_data = v;
    @(posedge clk);
    @(negedge clk);
    bd_we = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[int'(a) + i] = v[8 * i +: 8];
  endtask

  // Called on a falling edge; returns on the falling edge where resp_valid is seen.
  task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] ld,
                        output logic ill, output logic mis);
    logic e_ill, e_mis, got;
    int e_lat, e_mr, e_mw;
    int mr_n, mw_n, busy_ready, overlap, addr_bad, stray;
    logic [31:0] wa;
    model(rd, wr, f3, a, d, e_ill, e_mis, e_lat, e_mr, e_mw);
    exp_q.push_back(last_load);
    wa = {a[31:2], 2'b00};
    mr_n = 0; mw_n = 0; busy_ready = 0; overlap = 0; addr_bad = 0; stray = 0;
    got = 1'b0; lat = 0; ld = '0; ill = 1'b0; mis = 1'b0;
    chk("ready_at_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_read = rd; req_write = wr; funct3 = f3; addr = a; store_data = d;
    @(posedge clk);
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0; req_read = $urandom_range(0, 1); req_write = $urandom_range(0, 1);
        addr = $urandom; store_data = $urandom; funct3 = 3'($urandom_range(0, 7));
      end
      if (MemRead) mr_n++;
      if (MemWrite) mw_n++;
      if (MemRead && MemWrite) overlap++;
      if ((MemRead || MemWrite) && Mem_Addr !== wa) addr_bad++;
      if (resp_valid) begin
        got = 1'b1; lat = c; ld = load_data; ill = illegal; mis = misaligned;
      end else begin
        if (req_ready) busy_ready++;
        if (misaligned || illegal) stray++;
      end
    end
    chk("resp_seen", {31'd0, got}, 32'd1);
    chk("latency", lat, e_lat);
    chk("illegal", {31'd0, ill}, {31'd0, e_ill});
    chk("misaligned", {31'd0, mis}, {31'd0, e_mis});
    chk("load_data", ld, exp_q.pop_front());
    chk("memread_cycles", mr_n, e_mr);
    chk("memwrite_cycles", mw_n, e_mw);
    chk("strobe_overlap", overlap, 0);
    chk("mem_addr", addr_bad, 0);
    chk("ready_while_busy", busy_ready, 0);
    chk("stray_flags", stray, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_ld;
    logic        exp_ill;
    logic        exp_mis;
    int          exp_lat;
    logic        b2b;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    logic [31:0] ld;
    logic ill, mis;
    int resp_n;
    logic [2:0] f3;
    logic [31:0] a;
    logic rd, wr;

    reset = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    funct3 = '0; addr = '0; store_data = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;

    vecs.push_back('{1, 0, 3'b000, 32'h11,  32'h0,        32'hFFFFFFAA, 0, 0, 2, 0});
    vecs.push_back('{1, 0, 3'b100, 32'h11,  32'h0,        32'h000000AA, 0, 0, 2, 0});
    vecs.push_back('{1, 0, 3'b001, 32'h12,  32'h0,        32'hFFFF8899, 0, 0, 2, 0});
    vecs.push_back('{1, 0, 3'b101, 32'h12,  32'h0,        32'h00008899, 0, 0, 2, 0});
    vecs.push_back('{1, 0, 3'b010, 32'h10,  32'h0,        32'h8899AABB, 0, 0, 2, 0});
    vecs.push_back('{0, 1, 3'b000, 32'h13,  32'h12345677, 32'h8899AABB, 0, 0, 3, 0});
    vecs.push_back('{1, 0, 3'b010, 32'h10,  32'h0,        32'h7799AABB, 0, 0, 2, 0});
    vecs.push_back('{0, 1, 3'b001, 32'h12,  32'h0000BEEF, 32'h7799AABB, 0, 0, 3, 0});
    vecs.push_back('{1, 0, 3'b010, 32'h10,  32'h0,        32'hBEEFAABB, 0, 0, 2, 0});
    vecs.push_back('{1, 0, 3'b010, 32'h06,  32'h0,        32'hBEEFAABB, 0, 1, 1, 0});
    vecs.push_back('{1, 0, 3'b010, 32'hFC,  32'h0,        32'h00000000, 0, 0, 2, 0});
    vecs.push_back('{1, 0, 3'b010, 32'h100, 32'h0,        32'h00000000, 1, 0, 1, 0});
    vecs.push_back('{1, 0, 3'b011, 32'h10,  32'h0,        32'h00000000, 1, 0, 1, 0});
    vecs.push_back('{1, 1, 3'b010, 32'h10,  32'h0,        32'h00000000, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 3'b010, 32'h10,  32'h0,        32'h00000000, 1, 0, 1, 0});
    vecs.push_back('{0, 1, 3'b100, 32'h10,  32'h0,        32'h00000000, 1, 0, 1, 0});
    vecs.push_back('{1, 0, 3'b010, 32'h101, 32'h0,        32'h00000000, 1, 0, 1, 0});
    vecs.push_back('{1, 0, 3'b001, 32'h13,  32'h0,        32'h00000000, 0, 1, 1, 0});
    vecs.push_back('{0, 1, 3'b001, 32'h31,  32'h0,        32'h00000000, 0, 1, 1, 0});
    vecs.push_back('{0, 1, 3'b010, 32'h30,  32'hCAFEF00D, 32'h00000000, 0, 0, 2, 0});
    vecs.push_back('{1, 0, 3'b010, 32'h30,  32'h0,        32'hCAFEF00D, 0, 0, 2, 1});
    vecs.push_back('{1, 0, 3'b100, 32'h33,  32'h0,        32'h000000CA, 0, 0, 2, 1});

    // Reset state, then preload while still in reset.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_flags", {30'd0, misaligned, illegal}, 32'd0);
    chk("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_mem_addr", Mem_Addr, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    set_word(8'h10, 32'h8899AABB);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      if (!vecs[i].b2b) @(negedge clk);
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].d, lat, ld, ill, mis);
      chk($sformatf("vec%0d_load_data", i), ld, vecs[i].exp_ld);
      chk($sformatf("vec%0d_illegal", i), {31'd0, ill}, {31'd0, vecs[i].exp_ill});
      chk($sformatf("vec%0d_misaligned", i), {31'd0, mis}, {31'd0, vecs[i].exp_mis});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
    end
    chk("word10_after_stores", mem_word(32'h10), 32'hBEEFAABB);
    chk("word30_after_sw", mem_word(32'h30), 32'hCAFEF00D);

    // Reset asserted while the SB sits in RMW_RD.
    @(negedge clk);
    set_word(8'h20, 32'h11223344);
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; funct3 = 3'b000;
    addr = 32'h20; store_data = 32'h0000_0055;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rmw_memread", {31'd0, MemRead}, 32'd1);
    chk("rmw_ready_low", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_mid_memread", {31'd0, MemRead}, 32'd0);
    chk("rst_mid_memwrite", {31'd0, MemWrite}, 32'd0);
    resp_n = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) resp_n++;
    end
    reset = 1'b1;
    last_load = '0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) resp_n++;
    end
    chk("rst_mid_no_resp", resp_n, 0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_load_data", load_data, 32'd0);
    chk("rst_mid_mem_addr", Mem_Addr, 32'd0);
    chk("rst_mid_wr_data", wr_data, 32'd0);
    chk("rst_mid_word20", mem_word(32'h20), 32'h11223344);

    // Randomized requests against the reference model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        rd = $urandom_range(0, 1); wr = rd;
      end else begin
        rd = $urandom_range(0, 1); wr = !rd;
      end
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (rd) f3 = 3'($urandom_range(0, 4) == 3 ? 5 : $urandom_range(0, 4) % 3);
      else f3 = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) a = $urandom_range(32'hF0, 32'h10F);
      else a = $urandom_range(0, 32'h4F);
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      do_req(rd, wr, f3, a, $urandom, lat, ld, ill, mis);
    end

    @(negedge clk);
    for (int w = 0; w < MEM_BYTES; w += 4) begin
      chk($sformatf("mem_word_%02h", w), mem_word(w),
          {ref_mem[w + 3], ref_mem[w + 2], ref_mem[w + 1], ref_mem[w]});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage front end between the EX/MEM pipeline register and the byte-addressable data memory.
- Accepts one load or store request at a time and handles all RV32I access widths: LB/LH/LW/LBU/LHU and SB/SH/SW.
- Issues word-aligned accesses to the memory. Sub-word stores are done as read-modify-write, because the memory always writes 4 bytes. Load data is sign- or zero-extended.
- Flags misaligned, illegal and out-of-range accesses and stalls the pipeline via req_ready while busy.

Parameters:
- MEM_BYTES, 256, data memory size in bytes; accesses with word_addr+3 >= MEM_BYTES are faults.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present from EX/MEM.
- req_ready  out  1  high only in IDLE; request accepted on a rising edge when req_valid & req_ready.
- req_read  in  1  load request.
- req_write  in  1  store request.
- funct3  in  3  RISC-V width/sign code.
- addr  in  32  byte address.
- store_data  in  32  store value (low bits used for SB/SH).
- resp_valid  out  1  one-cycle completion pulse.
- load_data  out  32  extended load result; valid with resp_valid on loads.
- misaligned  out  1  valid with resp_valid.
- illegal  out  1  valid with resp_valid; bad funct3, bad op, or out of range.
- MemRead  out  1  to data memory.
- MemWrite  out  1  to data memory.
- Mem_Addr  out  32  to data memory; always {addr[31:2],2'b00}.
- wr_data  out  32  to data memory.
- rd_data  in  32  combinational read data from memory.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. resp_valid, misaligned, illegal, MemRead, MemWrite = 0. load_data, Mem_Addr, wr_data and all internal latches = 0.
- States: IDLE, LOAD, RMW_RD, WRITE.
- IDLE:
  - req_ready=1; MemRead=MemWrite=0.
  - On accept, latch addr, funct3, store_data and op, then classify:
    - Illegal if req_read==req_write, a load funct3 is in {011,110,111}, a store funct3 is not in {000,001,010}, or {addr[31:2],2'b00}+3 >= MEM_BYTES.
    - Otherwise misaligned if a halfword access has addr[0]=1 or a word access has addr[1:0]!=0.
    - illegal has priority over misaligned.
  - On a fault: stay in IDLE, pulse resp_valid with the flag next cycle, make no memory access.
  - Otherwise go to LOAD (load), WRITE (SW) or RMW_RD (SB/SH).
- LOAD (1 cycle):
  - MemRead=1. At the edge, extract the byte/half at addr[1:0] from rd_data (little-endian), extend it, and register it into load_data.
  - resp_valid=1 next cycle; go to IDLE.
- RMW_RD (1 cycle): MemRead=1. At the edge, capture rd_data, merge the store byte/half into lane addr[1:0] of the captured word, and go to WRITE.
- WRITE (1 cycle):
  - MemWrite=1; wr_data = merged word (SB/SH) or store_data (SW). The memory commits at the edge leaving WRITE.
  - resp_valid=1 next cycle; go to IDLE.
- MemRead and MemWrite are never both high. Both are decoded from the state register, so they drop as soon as reset asserts.
- Latency, counted from the accept edge to the resp_valid cycle:
  - Faults: 1 cycle.
  - Loads and SW: 2 cycles.
  - SB/SH: 3 cycles.
- A new request can be accepted in the same cycle resp_valid is high, giving back-to-back operation.
- load_data holds its value until the next load completes. It is not updated by stores or faults.
- misaligned and illegal are meaningful only while resp_valid=1 and read 0 otherwise.
- Reset mid-operation: the in-flight request is abandoned. If reset asserts before the edge leaving WRITE, memory is unmodified and no resp_valid is produced.
- Inputs are ignored outside IDLE.

Test Plan:
1. Preload word 0x10 = 0x8899AABB.
   - LB 0x11 -> load_data 0xFFFFFFAA.
   - LBU 0x11 -> 0x000000AA.
   - LH 0x12 -> 0xFFFF8899.
   - LHU 0x12 -> 0x00008899.
   - LW 0x10 -> 0x8899AABB.
   - Each: resp_valid exactly 2 cycles after accept; MemRead high 1 cycle.
2. SB 0x13 with store_data 0x12345677 -> word 0x10 becomes 0x7799AABB. MemRead 1 cycle, then MemWrite 1 cycle with Mem_Addr=0x10; resp_valid 3 cycles after accept.
3. SH 0x12 with store_data 0x0000BEEF -> word becomes 0xBEEFAABB. Then LW 0x06 -> misaligned=1, no MemRead/MemWrite, resp_valid 1 cycle after accept.
4. LW 0xFC (in range) completes normally. LW 0x100 -> illegal=1. Load funct3=011 -> illegal=1. req_read=req_write=1 -> illegal=1.
5. Start SB 0x20; drop reset low during RMW_RD -> MemRead falls immediately; word 0x20 unchanged; no resp_valid; after release, req_ready=1 and outputs are zero.
6. Back-to-back: SW 0x30=0xCAFEF00D accepted, then LW 0x30 accepted in the resp_valid cycle -> load_data 0xCAFEF00D; req_ready low in every non-IDLE cycle.
